fb_scroll_sched: RTL and testbench

Sequencer and owner of the single-port waterfall frame buffer. It clears the buffer, then drives video read addresses with a circular row offset. During lower blanking it copies one spectrum line from the frequency-bin BRAM into the buffer and advances the scroll offset. It sits between the `video` timing module, the frequency-bin BRAM read port and the frame buffer `ram`.

---
 rtl/fb_scroll_sched_if.sv | 13 +
 rtl/fb_scroll_sched.sv | 144 ++++++++++++++
 tb/tb_fb_scroll_sched.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_scroll_sched_if.sv
// fb_scroll_sched_if: frequency-bin BRAM read port and frame buffer write/read port
interface fb_scroll_sched_if #(
  parameter int ADDR_W = 17
);
  logic [8:0]        line_raddr;
  logic              line_ren;
  logic [7:0]        line_rdata;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_wdata;
  logic              fb_we;
  modport master (output line_raddr, line_ren, fb_addr, fb_wdata, fb_we, input line_rdata);
  modport slave  (input line_raddr, line_ren, fb_addr, fb_wdata, fb_we, output line_rdata);
endinterface

// File: rtl/fb_scroll_sched.sv
// fb_scroll_sched: clears the waterfall frame buffer, scans it for video with a circular row offset, and copies one spectrum line per scroll step
module fb_scroll_sched #(
  parameter int WIDTH           = 320,
  parameter int HEIGHT          = 240,
  parameter int SCROLL_DIV_BITS = 2,
  parameter int ADDR_W          = 17
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [8:0]        x,
  input  logic [7:0]        y,
  input  logic              lower_blank,
  input  logic              scroll_en,
  input  logic              clear_req,
  fb_scroll_sched_if.master bus,
  output logic [7:0]        y_offset,
  output logic              busy_clear,
  output logic              line_done,
  output logic              overrun
);
  typedef enum logic [1:0] {CLEAR, VIDEO, WRITE_LINE, WAIT_BLANK_END} state_t;
  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] W_P1   = ADDR_W'(WIDTH + 1);
  localparam logic [ADDR_W-1:0] H_A    = ADDR_W'(HEIGHT);
  localparam logic [ADDR_W-1:0] N_A    = ADDR_W'(WIDTH * HEIGHT);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
  localparam logic [7:0]        Y_LAST = 8'(HEIGHT - 1);

  state_t state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d, cnt_inc, wbase, wbase_d, fb_addr_d, sum, row, vaddr;
  logic [SCROLL_DIV_BITS-1:0] scnt, scnt_d;
  logic [8:0] raddr_d;
  logic [7:0] wdata_d, y_offset_d;
  logic we_d, ren_d, busy_d, done_d, ovr_d, pend, pend_d, lb_q, rise, step_now;

  assign rise     = lower_blank & ~lb_q;
  assign step_now = scroll_en & (&scnt);
  assign cnt_inc  = cnt + ONE;
  assign sum      = ADDR_W'(y) + ADDR_W'(y_offset);
  assign row      = sum >= H_A ? sum - H_A : sum;
  assign vaddr    = (ADDR_W'(x) >= W_A || ADDR_W'(y) >= H_A) ? '0 : ADDR_W'(x) + row * W_A;

  // next-state and next-output values; every output is registered below
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    wbase_d    = wbase;
    scnt_d     = scnt;
    pend_d     = pend;
    fb_addr_d  = bus.fb_addr;
    wdata_d    = bus.fb_wdata;
    we_d       = 1'b0;
    ren_d      = 1'b0;
    raddr_d    = '0;
    y_offset_d = y_offset;
    busy_d     = busy_clear;
    done_d     = 1'b0;
    ovr_d      = 1'b0;
    case (state)
      CLEAR: begin
        we_d      = cnt != N_A;
        fb_addr_d = we_d ? cnt : vaddr;
        wdata_d   = 8'd0;
        cnt_d     = we_d ? cnt_inc : '0;
        busy_d    = we_d;
        state_d   = we_d ? CLEAR : VIDEO;
      end
      VIDEO, WAIT_BLANK_END: begin
        fb_addr_d = vaddr;
        if (clear_req || pend) begin
          state_d    = CLEAR;
          cnt_d      = '0;
          fb_addr_d  = '0;
          y_offset_d = '0;
          scnt_d     = '0;
          busy_d     = 1'b1;
          pend_d     = 1'b0;
        end else if (state == VIDEO && rise) begin
          scnt_d  = scroll_en ? scnt + SCROLL_DIV_BITS'(1) : scnt;
          state_d = step_now ? WRITE_LINE : WAIT_BLANK_END;
          ren_d   = step_now;
          cnt_d   = '0;
          wbase_d = ADDR_W'(y_offset) * W_A;
        end else if (state == WAIT_BLANK_END && !lower_blank) begin
          state_d = VIDEO;
        end
      end
      WRITE_LINE: begin
        pend_d    = pend | clear_req;
        cnt_d     = cnt_inc;
        ren_d     = cnt_inc < W_A;
        raddr_d   = ren_d ? 9'(cnt_inc) : '0;
        we_d      = cnt != '0 && cnt <= W_A;
        fb_addr_d = we_d ? wbase + cnt - ONE : bus.fb_addr;
        wdata_d   = we_d ? bus.line_rdata : bus.fb_wdata;
        if (cnt == W_P1) begin
          state_d    = WAIT_BLANK_END;
          cnt_d      = '0;
          y_offset_d = y_offset == Y_LAST ? '0 : y_offset + 8'd1;
          done_d     = 1'b1;
          ovr_d      = ~lower_blank;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= CLEAR;
      cnt            <= '0;
      wbase          <= '0;
      scnt           <= '0;
      pend           <= 1'b0;
      lb_q           <= 1'b0;
      bus.fb_addr    <= '0;
      bus.fb_wdata   <= '0;
      bus.fb_we      <= 1'b0;
      bus.line_raddr <= '0;
      bus.line_ren   <= 1'b0;
      y_offset       <= '0;
      busy_clear     <= 1'b1;
      line_done      <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      wbase          <= wbase_d;
      scnt           <= scnt_d;
      pend           <= pend_d;
      lb_q           <= lower_blank;
      bus.fb_addr    <= fb_addr_d;
      bus.fb_wdata   <= wdata_d;
      bus.fb_we      <= we_d;
      bus.line_raddr <= raddr_d;
      bus.line_ren   <= ren_d;
      y_offset       <= y_offset_d;
      busy_clear     <= busy_d;
      line_done      <= done_d;
      overrun        <= ovr_d;
    end
  end
endmodule

// File: tb/tb_fb_scroll_sched.sv
// tb_fb_scroll_sched: directed checks of clear, video addressing, line copy, scroll, clear request and reset
module tb_fb_scroll_sched;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int AW = 17;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [8:0] x = '0;
  logic [7:0] y = '0;
  logic       lower_blank = 1'b0;
  logic       scroll_en = 1'b1;
  logic       clear_req = 1'b0;
  logic [7:0] y_offset;
  logic       busy_clear, line_done, overrun;
  logic [45:0] outs;
  int checks = 0;
  int failures = 0;
  int sc_m = 0;
  int yo_m = 0;

  fb_scroll_sched_if #(.ADDR_W(AW)) bus();

  fb_scroll_sched #(.WIDTH(W), .HEIGHT(H), .SCROLL_DIV_BITS(2), .ADDR_W(AW)) dut (
    .clk(clk),
    .resetn(resetn),
    .x(x),
    .y(y),
    .lower_blank(lower_blank),
    .scroll_en(scroll_en),
    .clear_req(clear_req),
    .bus(bus.master),
    .y_offset(y_offset),
    .busy_clear(busy_clear),
    .line_done(line_done),
    .overrun(overrun)
  );

  assign outs = {bus.fb_addr, bus.fb_wdata, bus.fb_we, bus.line_raddr, bus.line_ren, y_offset, line_done, overrun};

  always #5 clk = ~clk;

  // frequency-bin BRAM: one-cycle read latency, data = address + 0x10
  always @(posedge clk) bus.line_rdata <= bus.line_ren ? 8'(bus.line_raddr) + 8'h10 : bus.line_rdata;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_clear;
    for (int i = 0; i < W * H; i++) begin
      step;
      checks++;
      if ({bus.fb_we, bus.fb_wdata, busy_clear, bus.fb_addr} !== {1'b1, 8'h00, 1'b1, 17'(i)}) begin
        failures++;
        $display("FAIL clear_cycle%0d got we=%0b wdata=%0h busy=%0b addr=%0d want we=1 wdata=0 busy=1 addr=%0d",
                 i, bus.fb_we, bus.fb_wdata, busy_clear, bus.fb_addr, i);
      end
    end
    step;
    checks++;
    if ({bus.fb_we, busy_clear, y_offset} !== 10'd0) begin
      failures++;
      $display("FAIL clear_end got we=%0b busy=%0b y_offset=%0d want 0 0 0", bus.fb_we, busy_clear, y_offset);
    end
    sc_m = 0;
    yo_m = 0;
  endtask

  task automatic video_chk(input int xi, input int yi, input int exp, input string nm);
    x = 9'(xi);
    y = 8'(yi);
    step;
    checks++;
    if (bus.fb_addr !== 17'(exp) || bus.fb_we !== 1'b0) begin
      failures++;
      $display("FAIL %s got addr=%0d we=%0b want addr=%0d we=0", nm, bus.fb_addr, bus.fb_we, exp);
    end
  endtask

  task automatic blank_edge(input int drop_at, input int clr_at);
    bit wr;
    int base;
    wr = scroll_en && sc_m == 3;
    if (scroll_en) sc_m = (sc_m + 1) % 4;
    x = '0;
    y = '0;
    lower_blank = 1'b1;
    if (!wr) begin
      for (int j = 1; j <= 4; j++) begin
        step;
        checks++;
        if (bus.line_ren !== 1'b0 || bus.fb_we !== 1'b0 || line_done !== 1'b0) begin
          failures++;
          $display("FAIL nowrite_j%0d got ren=%0b we=%0b done=%0b want 0 0 0", j, bus.line_ren, bus.fb_we, line_done);
        end
      end
      lower_blank = 1'b0;
      step;
      step;
      return;
    end
    base = yo_m * W;
    for (int j = 1; j <= W + 3; j++) begin
      step;
      checks++;
      if (bus.line_ren !== (j <= W)) begin
        failures++;
        $display("FAIL wr_ren_j%0d got=%0b want=%0b", j, bus.line_ren, j <= W);
      end
      if (j <= W) begin
        checks++;
        if (bus.line_raddr !== 9'(j - 1)) begin
          failures++;
          $display("FAIL wr_raddr_j%0d got=%0d want=%0d", j, bus.line_raddr, j - 1);
        end
      end
      checks++;
      if (bus.fb_we !== (j >= 3 && j <= W + 2)) begin
        failures++;
        $display("FAIL wr_we_j%0d got=%0b want=%0b", j, bus.fb_we, j >= 3 && j <= W + 2);
      end
      if (j >= 3 && j <= W + 2) begin
        checks++;
        if (bus.fb_addr !== 17'(base + j - 3) || bus.fb_wdata !== 8'(16 + j - 3)) begin
          failures++;
          $display("FAIL wr_data_j%0d got addr=%0d wdata=%0h want addr=%0d wdata=%0h",
                   j, bus.fb_addr, bus.fb_wdata, base + j - 3, 16 + j - 3);
        end
      end
      checks++;
      if (line_done !== (j == W + 3) || overrun !== (j == W + 3 && drop_at != 0)) begin
        failures++;
        $display("FAIL wr_pulse_j%0d got done=%0b overrun=%0b want done=%0b overrun=%0b",
                 j, line_done, overrun, j == W + 3, j == W + 3 && drop_at != 0);
      end
      if (j == W + 3) begin
        yo_m = (yo_m == H - 1) ? 0 : yo_m + 1;
        checks++;
        if (y_offset !== 8'(yo_m)) begin
          failures++;
          $display("FAIL wr_y_offset got=%0d want=%0d", y_offset, yo_m);
        end
      end
      if (j == drop_at) lower_blank = 1'b0;
      clear_req = (j == clr_at);
    end
    clear_req = 1'b0;
    lower_blank = 1'b0;
    step;
    checks++;
    if (line_done !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL wr_pulse_end got done=%0b overrun=%0b want 0 0", line_done, overrun);
    end
    if (clr_at != 0) begin
      checks++;
      if (busy_clear !== 1'b1 || y_offset !== 8'd0 || bus.fb_we !== 1'b0) begin
        failures++;
        $display("FAIL pend_clear_start got busy=%0b y_offset=%0d we=%0b want 1 0 0", busy_clear, y_offset, bus.fb_we);
      end
      run_clear;
    end else begin
      step;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) step;
    checks++;
    if (busy_clear !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy got=%0b want=1", busy_clear);
    end
    checks++;
    if (outs !== 46'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%0h want=0", outs);
    end
  endtask

  task automatic test_clear;
    resetn = 1'b1;
    run_clear;
  endtask

  task automatic test_video;
    video_chk(5, 2, 21, "video_x5_y2_off0");
    video_chk(9, 2, 0, "video_x_oob");
    video_chk(3, 4, 0, "video_y_oob");
    video_chk(7, 3, 31, "video_last");
    x = '0;
    y = '0;
  endtask

  task automatic test_scroll_write;
    repeat (4) blank_edge(0, 0);
    repeat (8) blank_edge(0, 0);
  endtask

  task automatic test_video_offset;
    checks++;
    if (y_offset !== 8'd3) begin
      failures++;
      $display("FAIL offset_setup got=%0d want=3", y_offset);
    end
    video_chk(5, 2, 13, "video_x5_y2_off3");
    video_chk(0, 0, 24, "video_x0_y0_off3");
    video_chk(7, 3, 23, "video_x7_y3_off3");
    video_chk(9, 0, 0, "video_x9_off3");
    x = '0;
    y = '0;
  endtask

  task automatic test_wrap_overrun;
    repeat (3) blank_edge(0, 0);
    blank_edge(4, 0);
  endtask

  task automatic test_scroll_disable;
    scroll_en = 1'b0;
    repeat (9) blank_edge(0, 0);
    scroll_en = 1'b1;
    repeat (4) blank_edge(0, 0);
  endtask

  task automatic test_clear_during_write;
    repeat (3) blank_edge(0, 0);
    blank_edge(0, 5);
  endtask

  task automatic test_reset_mid_write;
    repeat (3) blank_edge(0, 0);
    lower_blank = 1'b1;
    repeat (5) step;
    checks++;
    if (bus.line_ren !== 1'b1 || bus.fb_we !== 1'b1) begin
      failures++;
      $display("FAIL midwrite_active got ren=%0b we=%0b want 1 1", bus.line_ren, bus.fb_we);
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (outs !== 46'd0 || busy_clear !== 1'b1) begin
      failures++;
      $display("FAIL midwrite_reset got outs=%0h busy=%0b want outs=0 busy=1", outs, busy_clear);
    end
    lower_blank = 1'b0;
    step;
    step;
    resetn = 1'b1;
    run_clear;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_clear;
    test_video;
    test_scroll_write;
    test_video_offset;
    test_wrap_overrun;
    test_scroll_disable;
    test_clear_during_write;
    test_reset_mid_write;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
